// File: rtl/sramlike_bus_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: FSM states, owner
// identifiers and arbitration policy selectors.
package sramlike_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

endpackage

// File: rtl/sramlike_bus_arbiter.sv
// Merges the instruction- and data-cache SRAM-like ports onto one bridge port,
// keeping a single transaction outstanding at a time.
module sramlike_bus_arbiter
  import sramlike_bus_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_MODE_FIXED
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       lastServed_q, lastServed_d;

  logic       winner;
  logic       sel;
  logic       selReq;
  logic       fwd;
  logic       addrOk;
  logic       dataOk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_INST;
      lastServed_q <= OWNER_DATA;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lastServed_q <= lastServed_d;
    end
  end

  // On a round-robin tie the port that was not served last wins.
  always_comb begin
    if (ARB_MODE == ARB_MODE_RR) begin
      winner = (inst_req && data_req) ? ~lastServed_q : data_req;
    end else begin
      winner = data_req ? OWNER_DATA : OWNER_INST;
    end
  end

  assign sel    = (state_q == ST_IDLE) ? winner : owner_q;
  assign selReq = sel ? data_req : inst_req;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lastServed_d = lastServed_q;
    fwd          = 1'b0;
    addrOk       = 1'b0;
    dataOk       = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            fwd     = 1'b1;
            owner_d = winner;
            if (mem_addr_ok) begin
              addrOk  = 1'b1;
              state_d = ST_DATA;
            end else begin
              state_d = ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (!selReq) begin
            state_d = ST_IDLE;
          end else begin
            fwd = 1'b1;
            if (mem_addr_ok) begin
              addrOk  = 1'b1;
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (mem_data_ok) begin
            dataOk       = 1'b1;
            state_d      = ST_IDLE;
            lastServed_d = owner_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Non-forwarding cycles present an all-zero request to the bridge.
  assign mem_req   = fwd;
  assign mem_wr    = fwd & (sel ? data_wr : inst_wr);
  assign mem_size  = fwd ? (sel ? data_size : inst_size) : 2'b00;
  assign mem_addr  = fwd ? (sel ? data_addr : inst_addr) : 32'h0;
  assign mem_wdata = fwd ? (sel ? data_wdata : inst_wdata) : 32'h0;

  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign inst_addr_ok = addrOk & (sel == OWNER_INST);
  assign data_addr_ok = addrOk & (sel == OWNER_DATA);
  assign inst_data_ok = dataOk & (sel == OWNER_INST);
  assign data_data_ok = dataOk & (sel == OWNER_DATA);

endmodule

// File: doc/sramlike_bus_arbiter.md
SRAMLIKE_BUS_ARBITER -- requirements
Module: sramlike_bus_arbiter

Interface
REQ-001 Parameter: ARB_MODE, 0, arbitration policy: 0 = fixed data-port priority, 1 = round-robin.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: inst_req / inst_wr  input  1 each  instruction-cache request and write flag, held until inst_addr_ok.
REQ-005 Port: inst_size  input  2; inst_addr, inst_wdata  input  32 each.
REQ-006 Port: inst_rdata  output  32; inst_addr_ok, inst_data_ok  output  1 each.
REQ-007 Port: data_req, data_wr  input  1; data_size  input  2; data_addr, data_wdata  input  32: data-cache request group, same protocol.
REQ-008 Port: data_rdata  output  32; data_addr_ok, data_data_ok  output  1 each.
REQ-009 Port: mem_req, mem_wr  output  1; mem_size  output  2; mem_addr, mem_wdata  output  32: toward the AXI bridge.
REQ-010 Port: mem_rdata  input  32; mem_addr_ok, mem_data_ok  input  1 each.

Function
REQ-011 FSM states SHALL be IDLE, ADDR (owner granted, waiting for mem_addr_ok) and DATA (waiting for mem_data_ok); the owner register is 1 bit (0 = inst, 1 = data).
REQ-012 In IDLE, the winner SHALL be chosen combinationally in the same cycle. ARB_MODE=0: data wins whenever data_req=1. ARB_MODE=1: on a tie, the port not served last wins; a single requester always wins.
REQ-013 In IDLE with any request, mem_req/wr/size/addr/wdata SHALL equal the winner's signals in that cycle (zero-cycle grant latency).
REQ-014 IDLE with winner and mem_addr_ok=1 -> DATA; winner's addr_ok=1 that cycle; owner <= winner.
REQ-015 IDLE with winner and mem_addr_ok=0 -> ADDR; owner <= winner; the grant is locked.
REQ-016 In ADDR, mem_* SHALL follow the owner only; the other port's request is ignored. mem_addr_ok=1 -> owner addr_ok=1, go to DATA.
REQ-017 In ADDR, if owner req=0 (requester abort), the FSM SHALL return to IDLE next cycle with no addr_ok issued.
REQ-018 In DATA, mem_req SHALL be 0. mem_data_ok=1 -> owner data_ok=1, go to IDLE, and the round-robin last-served bit <= owner.
REQ-019 Exactly one transaction SHALL be outstanding. A new grant is possible no earlier than the cycle after data_ok (one-cycle IDLE bubble).
REQ-020 mem_data_ok in IDLE or ADDR, and mem_addr_ok in DATA, SHALL be ignored with no state change and no ok pulses.
REQ-021 inst_rdata and data_rdata SHALL both equal mem_rdata; the non-owner's addr_ok and data_ok SHALL always be 0.
REQ-022 In IDLE with no request, all mem_* outputs SHALL be 0.

Reset
REQ-023 During reset: state=IDLE, owner=0, last-served=1 (inst wins the first round-robin tie). mem_req, mem_wr, and all addr_ok/data_ok outputs SHALL be 0 from the cycle after rst is sampled high.
REQ-024 Reset mid-transaction SHALL drop the outstanding transaction without issuing an ok pulse; the bridge is reset by the same rst.

Structure
REQ-025 The shared package SHALL hold the state encoding (IDLE=2'b00, ADDR=2'b01, DATA=2'b10), the owner encoding, and the ARB_MODE constants.
REQ-026 The block SHALL be a single module with no sub-modules; the arbitration pick is inline logic.

Verification
REQ-027 Simultaneous inst_req and data_req at addr 0x1FC0_0000 / 0x8000_0010, ARB_MODE=0, mem_addr_ok same cycle -> mem_addr=0x8000_0010, data_addr_ok=1, inst_addr_ok=0; inst is granted the cycle after data_data_ok.
REQ-028 ARB_MODE=1, both ports requesting continuously, with 4 transactions -> grant order inst, data, inst, data.
REQ-029 Data write to 0x0000_0040, wdata 0xDEADBEEF, size 2, with mem_addr_ok delayed 3 cycles -> FSM stays in ADDR 3 cycles; inst_req arriving during ADDR is not forwarded; mem_wr=1 is held.
REQ-030 Read with mem_data_ok 5 cycles after mem_addr_ok, mem_rdata=0x12345678 -> owner data_ok pulses exactly once for 1 cycle with rdata 0x12345678; mem_req=0 throughout DATA.
REQ-031 Spurious mem_data_ok=1 in IDLE -> no ok pulse and FSM stays in IDLE; rst asserted in DATA -> IDLE next cycle and no data_ok emitted.
REQ-032 Owner drops inst_req while in ADDR -> IDLE next cycle, with no addr_ok on either port.
